// File: rtl/nfsr_pkg.sv
// Shared constants and FSM state encoding for the nfsr keystream sequencer.
package nfsr_pkg;

    localparam int NFSR_WIDTH     = 24;
    localparam int DEFAULT_WARMUP = 48;
    localparam int BYTE_W         = 8;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_LOAD_ENC = 3'd1;
    localparam logic [2:0] ST_WARM_ENC = 3'd2;
    localparam logic [2:0] ST_RUN_ENC  = 3'd3;
    localparam logic [2:0] ST_HOLD_ENC = 3'd4;
    localparam logic [2:0] ST_FIN_ENC  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_LOAD = ST_LOAD_ENC,
        ST_WARM = ST_WARM_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_HOLD = ST_HOLD_ENC,
        ST_FIN  = ST_FIN_ENC
    } ks_state_e;

    // Width of a counter that runs 0 .. warmup-1 (at least one bit).
    function automatic int warm_cnt_width(input int warmup);
        return (warmup > 1) ? $clog2(warmup) : 1;
    endfunction

endpackage

// File: rtl/ks_byte_packer.sv
// Collects serial keystream bits MSB-first into a byte and flags when 8 bits are in.
module ks_byte_packer
    import nfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_i,
    input  logic              ser_i,
    input  logic              clear_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              full_o,
    output logic              last_o
);

    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] sr_q;
    logic              full_q;

    // Clear wins over shift so an abort mid-byte never leaves a partial count behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_q  <= 3'd0;
            sr_q   <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            bit_q  <= 3'd0;
            sr_q   <= '0;
            full_q <= 1'b0;
        end else if (shift_i) begin
            sr_q  <= {sr_q[BYTE_W-2:0], ser_i};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                full_q <= 1'b1;
            end
        end
    end

    assign byte_o = sr_q;
    assign full_o = full_q;
    assign last_o = (bit_q == 3'd7);

endmodule

// File: rtl/nfsr_keystream_ctrl.sv
// Sequencer for one nfsr: seed load, warm-up shifting, then byte-wise keystream
// delivery over a valid/ready handshake.
module nfsr_keystream_ctrl
    import nfsr_pkg::*;
#(
    parameter int WIDTH  = NFSR_WIDTH,
    parameter int WARMUP = DEFAULT_WARMUP,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] num_bytes,
    output logic             nfsr_load,
    output logic             nfsr_shift,
    output logic [WIDTH-1:0] nfsr_seed,
    input  logic             nfsr_ser,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int                WARM_W    = warm_cnt_width(WARMUP);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    ks_state_e         state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  seed_q, seed_d;
    logic              load_q, shift_q, valid_q, busy_q, done_q;

    logic              abort_hit;
    logic              accept;
    logic              pk_shift;
    logic              pk_clear;
    logic              pk_full;
    logic              pk_last;
    logic [7:0]        pk_byte;

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready
    // are both high and abort is low; byte_valid never depends on byte_ready, and
    // byte_data is held unchanged from the rise of byte_valid until that transfer.
    always_comb begin
        abort_hit = abort && (state_q inside {ST_LOAD, ST_WARM, ST_RUN, ST_HOLD});
        accept    = byte_valid && byte_ready && !abort;
        pk_shift  = (state_q == ST_RUN);
        pk_clear  = accept || abort_hit || (state_q == ST_LOAD);
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d  = seed_in;
                    cnt_d   = num_bytes;
                    state_d = (num_bytes == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                warm_d  = '0;
                state_d = ST_WARM;
            end
            ST_WARM: begin
                if (warm_q == WARM_LAST) begin
                    warm_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (pk_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // cnt_q is at least 1 here, so the decrement cannot wrap.
                if (accept) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? ST_FIN : ST_RUN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs are registered straight from the next state so they track the state flop exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            load_q  <= (state_d == ST_LOAD);
            shift_q <= (state_d == ST_WARM) || (state_d == ST_RUN);
            valid_q <= (state_d == ST_HOLD);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FIN);
        end
    end

    ks_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .shift_i (pk_shift),
        .ser_i   (nfsr_ser),
        .clear_i (pk_clear),
        .byte_o  (pk_byte),
        .full_o  (pk_full),
        .last_o  (pk_last)
    );

    assign nfsr_load  = load_q;
    assign nfsr_shift = shift_q;
    assign nfsr_seed  = seed_q;
    assign byte_data  = pk_byte;
    assign byte_valid = valid_q && pk_full;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule
